// File: rtl/mem_integrity_chk.sv
// Passive shadow-table checker: compares every memory read against the last value written to that address.
// Optional build macro MEM_CHK_UNINIT_ERR_EN: a read of an untracked address is also reported as a mismatch.
module mem_integrity_chk #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int DEPTH = 16,
   parameter int CNTW  = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            write,
   input  logic            read,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   wdata,
   input  logic [DW-1:0]   rdata,
   output logic            err,
   output logic [AW-1:0]   err_addr,
   output logic [DW-1:0]   err_exp,
   output logic [DW-1:0]   err_got,
   output logic            uninit_rd,
   output logic            full,
   output logic            ovf,
   output logic [CNTW-1:0] chk_cnt,
   output logic [CNTW-1:0] err_cnt
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] r_valid;
   logic [AW-1:0]    r_addr [DEPTH];
   logic [DW-1:0]    r_data [DEPTH];

   logic             r_err;
   logic [AW-1:0]    r_err_addr;
   logic [DW-1:0]    r_err_exp;
   logic [DW-1:0]    r_err_got;
   logic             r_uninit;
   logic             r_ovf;
   logic [CNTW-1:0]  r_chk_cnt;
   logic [CNTW-1:0]  r_err_cnt;

   logic             w_wr;
   logic             w_rd;
   logic [DEPTH-1:0] w_match;
   logic             w_hit;
   logic [IW-1:0]    w_hit_idx;
   logic [DW-1:0]    w_hit_data;
   logic             w_free_any;
   logic [IW-1:0]    w_free_idx;
   logic [DEPTH-1:0] w_wr_en;
   logic             w_ovf;
   logic             w_rd_hit;
   logic             w_rd_miss;
   logic             w_mis;
   logic             w_err_ev;
   logic [DW-1:0]    w_err_exp;

   // Index of the lowest set bit; zero when the vector is empty.
   function automatic logic [IW-1:0] lowest_set(input logic [DEPTH-1:0] vec);
      logic [IW-1:0] idx;
      idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
      return idx;
   endfunction

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + CNTW'(1);
   endfunction

   // Unknown strobes must not act as a transfer, so only a definite 1 qualifies.
   assign w_wr = (write === 1'b1);
   assign w_rd = (read  === 1'b1);

   // Associative lookup of the bus address against all valid entries.
   always_comb begin
      w_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_match[i] = r_valid[i] && (r_addr[i] == addr);
      end
   end

   assign w_hit      = |w_match;
   assign w_hit_idx  = lowest_set(w_match);
   assign w_hit_data = r_data[w_hit_idx];
   assign w_free_any = ~(&r_valid);
   assign w_free_idx = lowest_set(~r_valid);
   assign full       = &r_valid;

   // Write steering: update a hit in place, else claim the lowest free entry, else drop.
   always_comb begin
      w_wr_en = '0;
      w_ovf   = 1'b0;
      if (w_wr) begin
         if (w_hit) begin
            w_wr_en[w_hit_idx] = 1'b1;
         end else if (w_free_any) begin
            w_wr_en[w_free_idx] = 1'b1;
         end else begin
            w_ovf = 1'b1;
         end
      end else begin
         w_ovf = 1'b0;
      end
   end

   // Read classification uses the table as it was before any same-edge write.
   assign w_rd_hit  = w_rd & w_hit;
   assign w_rd_miss = w_rd & ~w_hit;
   assign w_mis     = w_rd_hit & (rdata != w_hit_data);

`ifdef MEM_CHK_UNINIT_ERR_EN
   assign w_err_ev  = w_mis | w_rd_miss;
   assign w_err_exp = w_mis ? w_hit_data : {DW{1'b0}};
`else
   assign w_err_ev  = w_mis;
   assign w_err_exp = w_hit_data;
`endif

   // Shadow table storage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_en[i]) begin
               r_valid[i] <= 1'b1;
               r_addr[i]  <= addr;
               r_data[i]  <= wdata;
            end
         end
      end
   end

   // Registered flags, error capture and saturating counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err      <= 1'b0;
         r_uninit   <= 1'b0;
         r_ovf      <= 1'b0;
         r_err_addr <= '0;
         r_err_exp  <= '0;
         r_err_got  <= '0;
         r_chk_cnt  <= '0;
         r_err_cnt  <= '0;
      end else begin
         r_err    <= w_err_ev;
         r_uninit <= w_rd_miss;
         r_ovf    <= w_ovf;
         if (w_rd_hit) begin
            r_chk_cnt <= sat_inc(r_chk_cnt);
         end
         if (w_err_ev) begin
            r_err_addr <= addr;
            r_err_exp  <= w_err_exp;
            r_err_got  <= rdata;
            r_err_cnt  <= sat_inc(r_err_cnt);
         end
      end
   end

   assign err       = r_err;
   assign err_addr  = r_err_addr;
   assign err_exp   = r_err_exp;
   assign err_got   = r_err_got;
   assign uninit_rd = r_uninit;
   assign ovf       = r_ovf;
   assign chk_cnt   = r_chk_cnt;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_mem_integrity_chk.sv
// Scoreboard bench for mem_integrity_chk: directed scenarios then randomized traffic against an
// associative-array reference model. Honours MEM_CHK_UNINIT_ERR_EN when defined.
module tb_mem_integrity_chk;

   localparam int DEPTH = 16;
   localparam int CNTW  = 6;
   localparam int CMAX  = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            write, read;
   logic [31:0]     addr, wdata, rdata;
   logic            err, uninit_rd, full, ovf;
   logic [31:0]     err_addr, err_exp, err_got;
   logic [CNTW-1:0] chk_cnt, err_cnt;

   mem_integrity_chk #(.AW(32), .DW(32), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk(clk), .reset_n(reset_n), .write(write), .read(read), .addr(addr),
      .wdata(wdata), .rdata(rdata), .err(err), .err_addr(err_addr), .err_exp(err_exp),
      .err_got(err_got), .uninit_rd(uninit_rd), .full(full), .ovf(ovf),
      .chk_cnt(chk_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err, uninit, ovf, full;
      logic [31:0] eaddr, eexp, egot;
      int          chk, errc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] shadow [logic [31:0]];
   int          m_chk, m_errc;
   logic [31:0] m_eaddr, m_eexp, m_egot;
   int          n_vec = 0;
   int          n_mis = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : CMAX;
   endfunction

   // Drive one bus cycle and push the model's view of the outputs after that edge.
   task automatic step(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdv);
      exp_t e;
      @(negedge clk);
      write = wr; read = rd; addr = a; wdata = wd; rdata = rdv;
      e.err = 1'b0; e.uninit = 1'b0; e.ovf = 1'b0;
      if (rd) begin
         if (shadow.exists(a)) begin
            m_chk = sat(m_chk);
            if (rdv != shadow[a]) begin
               e.err = 1'b1; m_eaddr = a; m_eexp = shadow[a]; m_egot = rdv;
               m_errc = sat(m_errc);
            end
         end else begin
            e.uninit = 1'b1;
`ifdef MEM_CHK_UNINIT_ERR_EN
            e.err = 1'b1; m_eaddr = a; m_eexp = 32'h0; m_egot = rdv;
            m_errc = sat(m_errc);
`endif
         end
      end
      if (wr) begin
         if (shadow.exists(a) || shadow.num() < DEPTH) shadow[a] = wd;
         else e.ovf = 1'b1;
      end
      e.full = (shadow.num() == DEPTH);
      e.eaddr = m_eaddr; e.eexp = m_eexp; e.egot = m_egot;
      e.chk = m_chk; e.errc = m_errc;
      q.push_back(e);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      write = 1'b0; read = 1'b0; addr = 32'h0; wdata = 32'h0; rdata = 32'h0;
      shadow.delete();
      q.delete();
      m_chk = 0; m_errc = 0; m_eaddr = 32'h0; m_eexp = 32'h0; m_egot = 32'h0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Monitor: every post-reset edge yields one set of outputs to compare.
   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (reset_n && q.size() > 0) begin
         e = q.pop_front();
         chk("err",       32'(err),       32'(e.err));
         chk("uninit_rd", 32'(uninit_rd), 32'(e.uninit));
         chk("ovf",       32'(ovf),       32'(e.ovf));
         chk("full",      32'(full),      32'(e.full));
         chk("err_addr",  err_addr,       e.eaddr);
         chk("err_exp",   err_exp,        e.eexp);
         chk("err_got",   err_got,        e.egot);
         chk("chk_cnt",   32'(chk_cnt),   32'(e.chk));
         chk("err_cnt",   32'(err_cnt),   32'(e.errc));
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [31:0] a, rdv;
      logic        wr, rd;
      reset_n = 1'b0;
      write = 1'b0; read = 1'b0; addr = 32'h0; wdata = 32'h0; rdata = 32'h0;
      m_chk = 0; m_errc = 0; m_eaddr = 32'h0; m_eexp = 32'h0; m_egot = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst err", 32'(err), 32'h0);
      chk("rst uninit", 32'(uninit_rd), 32'h0);
      chk("rst ovf", 32'(ovf), 32'h0);
      chk("rst full", 32'(full), 32'h0);
      chk("rst cnts", 32'({chk_cnt, err_cnt}), 32'h0);
      chk("rst err_data", err_addr | err_exp | err_got, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      idle(); idle();

      step(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0);
      step(1'b0, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF);
      settle();
      chk("t2 chk_cnt", 32'(chk_cnt), 32'd1);
      chk("t2 err", 32'(err), 32'h0);

      step(1'b0, 1'b1, 32'h10, 32'h0, 32'h0);
      settle();
      chk("t3 err", 32'(err), 32'h1);
      chk("t3 err_addr", err_addr, 32'h10);
      chk("t3 err_exp", err_exp, 32'hDEADBEEF);
      chk("t3 err_got", err_got, 32'h0);
      chk("t3 err_cnt", 32'(err_cnt), 32'd1);
      idle();
      settle();
      chk("t3 pulse end", 32'(err), 32'h0);

      step(1'b0, 1'b1, 32'h44, 32'h0, 32'h1234);
      settle();
      chk("t4 uninit", 32'(uninit_rd), 32'h1);
`ifdef MEM_CHK_UNINIT_ERR_EN
      chk("t4 err", 32'(err), 32'h1);
`else
      chk("t4 err", 32'(err), 32'h0);
`endif

      for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'hA000_0000 + 32'(i), 32'h0);
      settle();
      chk("t5 full", 32'(full), 32'h1);
      step(1'b1, 1'b0, 32'h300, 32'h1111, 32'h0);
      settle();
      chk("t5 ovf", 32'(ovf), 32'h1);
      step(1'b1, 1'b0, 32'h200, 32'hCAFE0000, 32'h0);
      settle();
      chk("t5 rewrite ovf", 32'(ovf), 32'h0);
      step(1'b0, 1'b1, 32'h200, 32'h0, 32'hCAFE0000);
      settle();
      chk("t5 readback err", 32'(err), 32'h0);
      step(1'b0, 1'b1, 32'h300, 32'h0, 32'h1111);
      settle();
      chk("t5 dropped uninit", 32'(uninit_rd), 32'h1);

      step(1'b1, 1'b1, 32'h10, 32'h5, 32'hDEADBEEF);
      settle();
      chk("t6 same-edge err", 32'(err), 32'h0);
      step(1'b0, 1'b1, 32'h10, 32'h0, 32'h5);
      settle();
      chk("t6 new data err", 32'(err), 32'h0);
      idle();

      do_reset();
      for (int n = 0; n < 600; n++) begin
         wr = ($urandom_range(0, 99) < 45);
         rd = ($urandom_range(0, 99) < 60);
         a  = 32'h100 + 32'($urandom_range(0, 19) * 4);
         if (shadow.exists(a) && $urandom_range(0, 99) < 70) rdv = shadow[a];
         else rdv = $urandom;
         step(wr, rd, a, $urandom, rdv);
      end
      idle(); idle();
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard drained", 32'(q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
